// File: rtl/dec_seq_onehot_if.sv
// dec_seq_onehot_if: select/step control and registered one-hot status bundle
interface dec_seq_onehot_if #(
  parameter int N    = 2,
  parameter int OUTS = 4
);
  logic            Enable;
  logic [N-1:0]    A;
  logic            load;
  logic [1:0]      mode;
  logic            step;
  logic [OUTS-1:0] Y;
  logic [N-1:0]    sel;
  logic            wrap;
  logic            err;
  modport master (output Enable, A, load, mode, step, input Y, sel, wrap, err);
  modport slave  (input Enable, A, load, mode, step, output Y, sel, wrap, err);
endinterface

// File: rtl/dec_seq_onehot.sv
// dec_seq_onehot: registered one-hot decoder with loadable, steppable select index
module dec_seq_onehot #(
  parameter int N    = 2,
  parameter int OUTS = 4
) (
  input logic             clk,
  input logic             rst,
  dec_seq_onehot_if.slave bus
);
  localparam logic [N:0]   OUTS_W = (N+1)'(OUTS);
  localparam logic [N-1:0] LAST   = N'(OUTS - 1);
  logic [N-1:0]    idx_q, idx_d;
  logic [OUTS-1:0] y_q, y_d;
  logic            wrap_q, wrap_d, err_q, err_d, a_ok, up, dn;
  // Wide compare so OUTS == 2**N never overflows the range check
  assign a_ok = {1'b0, bus.A} < OUTS_W;
  assign up   = bus.step && bus.Enable && bus.mode == 2'b01;
  assign dn   = bus.step && bus.Enable && bus.mode == 2'b10;
  // Next index: load beats direct mode beats stepping; wrap is an explicit boundary compare
  always_comb begin
    idx_d  = idx_q;
    err_d  = err_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      idx_d = a_ok ? bus.A : idx_q;
      err_d = !a_ok;
    end else if (bus.mode == 2'b11) begin
      idx_d = a_ok ? bus.A : idx_q;
      err_d = err_q || !a_ok;
    end else if (up) begin
      wrap_d = idx_q == LAST;
      idx_d  = wrap_d ? '0 : idx_q + 1'b1;
    end else if (dn) begin
      wrap_d = idx_q == '0;
      idx_d  = wrap_d ? LAST : idx_q - 1'b1;
    end
    y_d = bus.Enable ? (OUTS'(1) << idx_d) : '0;
  end
  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      y_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end
  assign bus.Y    = y_q;
  assign bus.sel  = idx_q;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;
endmodule
